// File: rtl/dm_responder_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package dm_responder_pkg;

    localparam int unsigned DATA_W      = 16;
    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned LATENCY_MIN = 2;
    localparam int unsigned LATENCY_MAX = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Request captured at the IDLE accept edge
    typedef struct packed {
        logic              op_wr;
        logic [DATA_W-1:0] data;
    } req_t;

    function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
        return (v == {DATA_W{1'b1}}) ? v : v + DATA_W'(1);
    endfunction

endpackage

// File: rtl/dm_responder_if.sv
// CPU MEM-stage to data-memory bus; master is the cpu, slave the responder.
interface dm_if;
    import dm_responder_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic              re;
    logic              we;
    logic [DATA_W-1:0] wrt_data;
    logic [DATA_W-1:0] rd_data;
    logic              mem_stall;
    logic              err;
    logic [DATA_W-1:0] rd_cnt;
    logic [DATA_W-1:0] wr_cnt;

    modport master (
        output addr, re, we, wrt_data,
        input  rd_data, mem_stall, err, rd_cnt, wr_cnt
    );

    modport slave (
        input  addr, re, we, wrt_data,
        output rd_data, mem_stall, err, rd_cnt, wr_cnt
    );

endinterface

// File: rtl/dm_responder_array.sv
// Single-port word RAM: synchronous write and registered read on one index.
module dm_array
    import dm_responder_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_idx,
    input  logic [DATA_W-1:0]     i_wdata,
    output logic [DATA_W-1:0]     o_rdata
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
        r_rdata <= r_mem[i_idx];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: one access at a time, LATENCY cycles of mem_stall,
// sticky re&we error flag and saturating read/write counters.
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 4
) (
    input logic clk,
    input logic rst_n,
    dm_if.slave io_mem
);

    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
        $fatal(1, "dm_responder: LATENCY %0d outside %0d..%0d", LATENCY, LATENCY_MIN, LATENCY_MAX);
    end

    state_t                r_state;
    state_t                w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [DEPTH_LOG2-1:0] r_idx;
    req_t                  r_req;
    logic                  r_err;
    logic [DATA_W-1:0]     r_rd_data;
    logic [DATA_W-1:0]     r_rd_cnt;
    logic [DATA_W-1:0]     r_wr_cnt;

    logic                  w_req;
    logic                  w_stall;
    logic                  w_accept;
    logic                  w_fire;
    logic                  w_ram_we;
    logic [DEPTH_LOG2-1:0] w_ram_idx;
    logic [DATA_W-1:0]     w_ram_rdata;

    assign w_req = io_mem.re | io_mem.we;

    // High address bits alias onto the array
    if (DEPTH_LOG2 < ADDR_W) begin : g_addr_alias
        logic w_unused_addr_hi;
        assign w_unused_addr_hi = ^io_mem.addr[ADDR_W-1:DEPTH_LOG2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_stall  = 1'b0;
        w_accept = 1'b0;
        w_fire   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_stall = w_req;
                if (w_req) begin
                    w_accept = 1'b1;
                    w_next   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_stall = 1'b1;
                if (r_cnt == '0) begin
                    w_fire = 1'b1;
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Request latch, latency countdown, completion side effects
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_idx     <= '0;
            r_req     <= '0;
            r_err     <= 1'b0;
            r_rd_data <= '0;
            r_rd_cnt  <= '0;
            r_wr_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_idx       <= io_mem.addr[DEPTH_LOG2-1:0];
                r_req.op_wr <= io_mem.we;
                r_req.data  <= io_mem.wrt_data;
                r_cnt       <= CNT_W'(LATENCY - 2);
                if (io_mem.re && io_mem.we) begin
                    r_err <= 1'b1;
                end
            end else if (r_state == ST_BUSY && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_fire) begin
                if (r_req.op_wr) begin
                    r_wr_cnt <= sat_inc(r_wr_cnt);
                end else begin
                    r_rd_data <= w_ram_rdata;
                    r_rd_cnt  <= sat_inc(r_rd_cnt);
                end
            end
        end
    end

    // Index the live address while IDLE so a LATENCY=2 read is ready in time
    assign w_ram_idx = (r_state == ST_IDLE) ? io_mem.addr[DEPTH_LOG2-1:0] : r_idx;
    assign w_ram_we  = w_fire & r_req.op_wr;

    dm_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_idx   (w_ram_idx),
        .i_wdata (r_req.data),
        .o_rdata (w_ram_rdata)
    );

    assign io_mem.mem_stall = w_stall;
    assign io_mem.rd_data   = r_rd_data;
    assign io_mem.err       = r_err;
    assign io_mem.rd_cnt    = r_rd_cnt;
    assign io_mem.wr_cnt    = r_wr_cnt;

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder against a word-array reference model.
module tb_dm_responder;

    localparam int unsigned DL   = 10;
    localparam int unsigned LAT  = 4;
    localparam int unsigned LAT2 = 2;
    localparam int          WORDS = 1 << DL;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    dm_if bus ();
    dm_if bus2 ();

    dm_responder #(.DEPTH_LOG2(DL), .LATENCY(LAT)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_mem (bus.slave)
    );

    dm_responder #(.DEPTH_LOG2(DL), .LATENCY(LAT2)) dut2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_mem (bus2.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] m_mem [WORDS];
    int          m_rd;
    int          m_rdc;
    int          m_wrc;
    int          m_err;
    int          written_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v < 65535) ? v + 1 : 65535;
    endfunction

    // One access by a stall-obeying cpu; scribbles inputs while stalled
    task automatic access(input bit r, input bit w, input logic [15:0] a,
                          input logic [15:0] d, input string tag);
        int n;
        int i;
        n = 0;
        @(negedge clk);
        bus.re = r; bus.we = w; bus.addr = a; bus.wrt_data = d;
        #1;
        while (bus.mem_stall === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
            bus.addr     = 16'($urandom);
            bus.wrt_data = 16'($urandom);
            #1;
        end
        i = int'(a) % WORDS;
        if (w) begin
            m_mem[i] = d;
            written_q.push_back(i);
            m_wrc = sat(m_wrc);
            if (r) m_err = 1;
        end else begin
            m_rd  = int'(m_mem[i]);
            m_rdc = sat(m_rdc);
        end
        check({tag, ":stall_cycles"}, 32'(n), 32'(LAT));
        check({tag, ":rd_data"}, 32'(bus.rd_data), 32'(m_rd));
        check({tag, ":rd_cnt"}, 32'(bus.rd_cnt), 32'(m_rdc));
        check({tag, ":wr_cnt"}, 32'(bus.wr_cnt), 32'(m_wrc));
        check({tag, ":err"}, 32'(bus.err), 32'(m_err));
        bus.re = 1'b0; bus.we = 1'b0;
    endtask

    initial begin
        logic [15:0] a;
        int kind;
        int pick;

        bus.re = 0; bus.we = 0; bus.addr = 0; bus.wrt_data = 0;
        bus2.re = 0; bus2.we = 0; bus2.addr = 0; bus2.wrt_data = 0;
        m_rd = 0; m_rdc = 0; m_wrc = 0; m_err = 0;

        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset:stall", 32'(bus.mem_stall), 32'd0);
        check("reset:rd_data", 32'(bus.rd_data), 32'd0);
        check("reset:err", 32'(bus.err), 32'd0);
        check("reset:rd_cnt", 32'(bus.rd_cnt), 32'd0);
        check("reset:wr_cnt", 32'(bus.wr_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        access(0, 1, 16'h0010, 16'h1234, "wr_0010");
        access(1, 0, 16'h0010, 16'h0000, "rd_0010");
        access(0, 1, 16'h0410, 16'hBEEF, "wr_alias_0410");
        access(1, 0, 16'h0010, 16'h0000, "rd_alias_0010");
        access(1, 1, 16'h0020, 16'h5555, "both_0020");
        access(1, 0, 16'h0020, 16'h0000, "rd_0020");
        access(0, 1, 16'h0030, 16'h1111, "wr_0030");

        // Reset on the 2nd BUSY cycle of a write aborts it
        @(negedge clk);
        bus.we = 1'b1; bus.re = 1'b0; bus.addr = 16'h0030; bus.wrt_data = 16'hAAAA;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0; bus.we = 1'b0;
        #1;
        check("abort:stall", 32'(bus.mem_stall), 32'd0);
        check("abort:rd_data", 32'(bus.rd_data), 32'd0);
        check("abort:wr_cnt", 32'(bus.wr_cnt), 32'd0);
        check("abort:rd_cnt", 32'(bus.rd_cnt), 32'd0);
        check("abort:err", 32'(bus.err), 32'd0);
        m_rd = 0; m_rdc = 0; m_wrc = 0; m_err = 0;
        @(negedge clk);
        rst_n = 1'b1;
        access(1, 0, 16'h0030, 16'h0000, "rd_after_abort");

        // Randomized traffic; reads only target words already written
        for (int t = 0; t < 40; t++) begin
            kind = int'($urandom_range(0, 3));
            if (kind == 0 || written_q.size() == 0) begin
                access(0, 1, 16'($urandom), 16'($urandom), "rand_wr");
            end else if (kind == 3) begin
                access(1, 1, 16'($urandom), 16'($urandom), "rand_both");
            end else begin
                pick = int'($urandom_range(0, written_q.size() - 1));
                a = 16'(written_q[pick] + WORDS * int'($urandom_range(0, 63)));
                access(1, 0, a, 16'($urandom), "rand_rd");
            end
        end

        // Saturation of the write counter
        @(negedge clk);
        force dut.r_wr_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.r_wr_cnt;
        #1;
        check("sat:preset", 32'(bus.wr_cnt), 32'h0000FFFE);
        m_wrc = 65534;
        for (int t = 0; t < 3; t++) begin
            access(0, 1, 16'($urandom), 16'($urandom), "sat_wr");
        end
        check("sat:final", 32'(bus.wr_cnt), 32'h0000FFFF);

        // LATENCY=2 instance with a continuously held read request
        @(negedge clk);
        bus2.re = 1'b1; bus2.addr = 16'h0005;
        for (int i = 0; i < 9; i++) begin
            #1;
            check("lat2:stall", 32'(bus2.mem_stall), 32'((i % 3) != 2));
            check("lat2:rd_cnt", 32'(bus2.rd_cnt), 32'((i + 1) / 3));
            @(negedge clk);
        end
        bus2.re = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
